rtc_bus_ctrl: RTL and testbench
===============================

RTC_BUS_CTRL -- requirements
Module: rtc_bus_ctrl

Interface
REQ-001 Parameter T_PH, default 10, gives clock cycles per bus phase; legal range 1..255.
REQ-002 clk  in  1  system clock; all logic on rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 start  in  1  one-cycle request from the init/step sequencer to execute one transfer.
REQ-005 op  in  1  1 = perform bus transfer; 0 = no-op step.
REQ-006 wr  in  1  1 = write, 0 = read; used only when ad = 1.
REQ-007 ad  in  1  0 = address phase, 1 = data phase.
REQ-008 addr  in  4  RTC register address, sent zero-extended in the address phase.
REQ-009 data_in  in  8  write data for the data phase.
REQ-010 bus_in  in  8  sampled multiplexed AD bus from the pad.
REQ-011 bus_out  out  8  value driven onto the AD bus.
REQ-012 bus_oe  out  1  1 = FPGA drives the AD bus.
REQ-013 cs_n, rd_n, wr_n, ad_n  out  1 each  active-low RTC chip select, read strobe, write strobe, and address/data select (ad_n = 0 in address phase).
REQ-014 rd_data  out  8  last byte read; rd_valid  out  1  one-cycle pulse when rd_data updates.
REQ-015 busy  out  1  transfer in progress; done  out  1  one-cycle completion pulse to the sequencer.

Function
REQ-016 FSM states: IDLE, SETUP, STROBE, HOLD, RECOVER, DONE; each of SETUP/STROBE/HOLD/RECOVER lasts exactly T_PH cycles, and DONE lasts 1 cycle.
REQ-017 IDLE: cs_n = rd_n = wr_n = ad_n = 1; bus_oe = 0; busy = 0.
REQ-018 start is sampled only in IDLE; start while busy is ignored, with no queuing.
REQ-019 start with op = 0 goes IDLE -> DONE: done pulses on the next cycle, with no strobe, cs_n, or bus activity.
REQ-020 start with op = 1 latches wr, ad, addr, and data_in, then enters SETUP; later input changes have no effect on the transfer.
REQ-021 SETUP: cs_n = 0; ad_n = latched ad; bus_oe = 1 unless this is a data-phase read; bus_out = {4'b0000, addr} if ad = 0, else data.
REQ-022 STROBE: address phase or write drives wr_n = 0; data-phase read drives rd_n = 0 with bus_oe = 0.
REQ-023 A read samples bus_in into rd_data on the last cycle of STROBE; rd_valid pulses on the following cycle.
REQ-024 HOLD: strobes return to 1; cs_n, ad_n, bus_out, and bus_oe are unchanged from STROBE.
REQ-025 RECOVER: cs_n = 1, ad_n = 1, bus_oe = 0.
REQ-026 DONE: done = 1 for one cycle, then the FSM returns to IDLE.
REQ-027 Latency: done is high exactly 4*T_PH+1 cycles after the start-sampling edge.
REQ-028 busy is high from the cycle after start through the DONE cycle inclusive.
REQ-029 wr_n and rd_n are never both 0; bus_oe is never 1 while rd_n = 0.
REQ-030 The phase counter reloads on each state entry and counts T_PH-1 down to 0, with no wrap-around.
REQ-031 start in the DONE cycle is ignored; back-to-back transfers therefore need start at or after the cycle following done.

Reset
REQ-032 When reset is high at a clock edge, the FSM goes to IDLE and all outputs return to their IDLE values, including mid-transfer.
REQ-033 Reset values: rd_data = 8'h00; rd_valid = 0; done = 0; bus_out = 8'h00; phase counter = 0.
REQ-034 A transfer interrupted by reset never asserts done.

Structure
REQ-035 The shared package holds: the state enum, T_PH_DEFAULT = 10, and the bus width constant 8.
REQ-036 One sub-module, phase_timer, provides the loadable down-counter with a zero flag; the FSM and bus muxing stay in rtc_bus_ctrl.

Verification (T_PH = 2 unless stated)
REQ-037 Address write, addr = 4'h2: bus_out = 8'h02, ad_n = 0, wr_n low 2 cycles, done at cycle 9.
REQ-038 Data write, data_in = 8'hD2: ad_n = 1, bus_out = 8'hD2 throughout SETUP..HOLD, rd_n stays 1.
REQ-039 Data read with bus_in = 8'h45 during STROBE: bus_oe = 0, rd_n low 2 cycles, rd_data = 8'h45, one rd_valid pulse.
REQ-040 start with op = 0: done on the next cycle, cs_n stays 1, busy high for 1 cycle.
REQ-041 Reset asserted in the 2nd STROBE cycle: next cycle all outputs are at IDLE values and done never pulses; a new start works normally.
REQ-042 start re-asserted while busy, plus T_PH = 1: the extra start is ignored, and done arrives at cycle 5 for the single transfer.

Source files
------------

// File: rtl/rtc_bus_ctrl_pkg.sv
// Shared types and constants for the RTC multiplexed-bus controller.
package rtc_bus_ctrl_pkg;

    localparam int unsigned T_PH_DEFAULT = 10;
    localparam int unsigned BUS_W        = 8;
    localparam int unsigned CNT_W        = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_RECOVER,
        ST_DONE
    } state_e;

endpackage

// File: rtl/rtc_bus_ctrl_phase_timer.sv
// Loadable down-counter that saturates at zero; zero flags the last cycle of a phase.
module phase_timer
    import rtc_bus_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (count_q != '0) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/rtc_bus_ctrl.sv
// Sequences one RTC bus transfer (address or data phase) through setup/strobe/hold/recover.
module rtc_bus_ctrl
    import rtc_bus_ctrl_pkg::*;
#(
    parameter int unsigned T_PH = T_PH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic             wr,
    input  logic             ad,
    input  logic [3:0]       addr,
    input  logic [7:0]       data_in,
    input  logic [BUS_W-1:0] bus_in,
    output logic [BUS_W-1:0] bus_out,
    output logic             bus_oe,
    output logic             cs_n,
    output logic             rd_n,
    output logic             wr_n,
    output logic             ad_n,
    output logic [7:0]       rd_data,
    output logic             rd_valid,
    output logic             busy,
    output logic             done
);

    state_e           state_q, state_d;
    logic             wr_q, wr_d;
    logic             ad_q, ad_d;
    logic [3:0]       addr_q, addr_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             phase_load;
    logic             phase_zero;
    logic             is_read;
    logic [BUS_W-1:0] bus_val;

    phase_timer u_phase_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (phase_load),
        .load_val (CNT_W'(T_PH - 1)),
        .zero     (phase_zero)
    );

    // Reload on every state change so each timed state runs exactly T_PH cycles.
    assign phase_load = (state_d != state_q);
    assign is_read    = ad_q && !wr_q;
    assign bus_val    = ad_q ? data_q : {{(BUS_W-4){1'b0}}, addr_q};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (start) state_d = op ? ST_SETUP : ST_DONE;
            ST_SETUP:   if (phase_zero) state_d = ST_STROBE;
            ST_STROBE:  if (phase_zero) state_d = ST_HOLD;
            ST_HOLD:    if (phase_zero) state_d = ST_RECOVER;
            ST_RECOVER: if (phase_zero) state_d = ST_DONE;
            ST_DONE:    state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cs_n    = 1'b1;
        rd_n    = 1'b1;
        wr_n    = 1'b1;
        ad_n    = 1'b1;
        bus_oe  = 1'b0;
        bus_out = '0;
        busy    = (state_q != ST_IDLE);
        done    = (state_q == ST_DONE);
        case (state_q)
            ST_SETUP, ST_STROBE, ST_HOLD: begin
                cs_n    = 1'b0;
                ad_n    = ad_q;
                bus_oe  = !is_read;
                bus_out = bus_val;
                if (state_q == ST_STROBE) begin
                    if (is_read) rd_n = 1'b0;
                    else         wr_n = 1'b0;
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        wr_d       = wr_q;
        ad_d       = ad_q;
        addr_d     = addr_q;
        data_d     = data_q;
        rd_data_d  = rd_data_q;
        rd_valid_d = 1'b0;
        if (state_q == ST_IDLE && start && op) begin
            wr_d   = wr;
            ad_d   = ad;
            addr_d = addr;
            data_d = data_in;
        end
        if (state_q == ST_STROBE && phase_zero && is_read) begin
            rd_data_d  = bus_in;
            rd_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q       <= 1'b0;
            ad_q       <= 1'b0;
            addr_q     <= '0;
            data_q     <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            wr_q       <= wr_d;
            ad_q       <= ad_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_rtc_bus_ctrl.sv
// Scoreboard bench: stimulus pushes hand-computed transfer summaries, a monitor checks them at done.
module tb_rtc_bus_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, op, wr, ad;
    logic [3:0] addr;
    logic [7:0] data_in, bus_in;

    logic [7:0] a_bus_out, a_rd_data, b_bus_out, b_rd_data, m_bus_out, m_rd_data;
    logic a_oe, a_cs_n, a_rd_n, a_wr_n, a_ad_n, a_rv, a_busy, a_done;
    logic b_oe, b_cs_n, b_rd_n, b_wr_n, b_ad_n, b_rv, b_busy, b_done;
    logic m_oe, m_cs_n, m_rd_n, m_wr_n, m_ad_n, m_rv, m_busy, m_done;
    logic sel = 1'b0;

    rtc_bus_ctrl #(.T_PH(2)) u0 (
        .clk(clk), .reset(reset), .start(start), .op(op), .wr(wr), .ad(ad),
        .addr(addr), .data_in(data_in), .bus_in(bus_in), .bus_out(a_bus_out),
        .bus_oe(a_oe), .cs_n(a_cs_n), .rd_n(a_rd_n), .wr_n(a_wr_n), .ad_n(a_ad_n),
        .rd_data(a_rd_data), .rd_valid(a_rv), .busy(a_busy), .done(a_done)
    );

    rtc_bus_ctrl #(.T_PH(1)) u1 (
        .clk(clk), .reset(reset), .start(start), .op(op), .wr(wr), .ad(ad),
        .addr(addr), .data_in(data_in), .bus_in(bus_in), .bus_out(b_bus_out),
        .bus_oe(b_oe), .cs_n(b_cs_n), .rd_n(b_rd_n), .wr_n(b_wr_n), .ad_n(b_ad_n),
        .rd_data(b_rd_data), .rd_valid(b_rv), .busy(b_busy), .done(b_done)
    );

    always_comb begin
        m_bus_out = sel ? b_bus_out : a_bus_out;
        m_rd_data = sel ? b_rd_data : a_rd_data;
        m_oe      = sel ? b_oe      : a_oe;
        m_cs_n    = sel ? b_cs_n    : a_cs_n;
        m_rd_n    = sel ? b_rd_n    : a_rd_n;
        m_wr_n    = sel ? b_wr_n    : a_wr_n;
        m_ad_n    = sel ? b_ad_n    : a_ad_n;
        m_rv      = sel ? b_rv      : a_rv;
        m_busy    = sel ? b_busy    : a_busy;
        m_done    = sel ? b_done    : a_done;
    end

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         s;
        int         lat;
        int         nb;
        int         ncs;
        int         nwr;
        int         nrd;
        int         noe;
        int         nad;
        int         nrv;
        logic [7:0] bus;
        logic [7:0] rdata;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   passed = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h required %0h (cyc %0d)", name, act, req, cyc);
    endtask

    // Monitor: accumulates one busy window and compares it against the queued record at done.
    bit open = 0;
    bit viol, busbad;
    int n_b, n_cs, n_wr, n_rd, n_oe, n_ad, n_rv;
    always @(negedge clk) begin
        exp_t r;
        if (!m_busy && !m_done) begin
            open = 0;
        end else begin
            if (!open) begin
                open = 1; viol = 0; busbad = 0;
                n_b = 0; n_cs = 0; n_wr = 0; n_rd = 0; n_oe = 0; n_ad = 0; n_rv = 0;
            end
            n_b  += int'(m_busy);
            n_cs += int'(!m_cs_n);
            n_wr += int'(!m_wr_n);
            n_rd += int'(!m_rd_n);
            n_oe += int'(m_oe);
            n_ad += int'(!m_ad_n);
            n_rv += int'(m_rv);
            if ((!m_wr_n && !m_rd_n) || (m_oe && !m_rd_n)) viol = 1;
            if (m_oe && q.size() > 0 && m_bus_out !== q[0].bus) busbad = 1;
            if (m_done) begin
                if (q.size() == 0) begin
                    total++;
                    $display("FAIL unexpected_done: got done=1 required done=0 (cyc %0d)", cyc);
                end else begin
                    r = q.pop_front();
                    chk("latency",   cyc - r.s + 1, r.lat);
                    chk("busy_cyc",  n_b,  r.nb);
                    chk("cs_low",    n_cs, r.ncs);
                    chk("wr_low",    n_wr, r.nwr);
                    chk("rd_low",    n_rd, r.nrd);
                    chk("oe_cyc",    n_oe, r.noe);
                    chk("ad_low",    n_ad, r.nad);
                    chk("rd_valid",  n_rv, r.nrv);
                    chk("bus_value", busbad, 0);
                    chk("strobe_rules", viol, 0);
                    if (r.nrv != 0) chk("rd_data", m_rd_data, r.rdata);
                end
                open = 0;
            end
        end
    end

    task automatic xfer(input int t, input bit op_i, input bit wr_i, input bit ad_i,
                        input logic [3:0] a_i, input logic [7:0] d_i, input logic [7:0] rb,
                        input int exa, input int exb,
                        input int lat, input int ncs, input int nwr, input int nrd,
                        input int noe, input int nad, input int nrv, input logic [7:0] ebus);
        exp_t r;
        sel = (t == 1);
        @(negedge clk);
        r.s = cyc + 1; r.lat = lat; r.nb = lat; r.ncs = ncs; r.nwr = nwr; r.nrd = nrd;
        r.noe = noe; r.nad = nad; r.nrv = nrv; r.bus = ebus; r.rdata = rb;
        q.push_back(r);
        start = 1'b1; op = op_i; wr = wr_i; ad = ad_i; addr = a_i; data_in = d_i;
        for (int n = 1; n <= lat + 2; n++) begin
            @(negedge clk);
            start   = (n == exa) || (n == exb);
            op      = 1'($urandom);
            wr      = 1'($urandom);
            ad      = 1'($urandom);
            addr    = 4'($urandom);
            data_in = 8'($urandom);
            bus_in  = (n == 2 * t) ? rb : 8'(8'h11 + n);
        end
        start = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_cs_n"},  a_cs_n, 1);
        chk({tag, "_rd_n"},  a_rd_n, 1);
        chk({tag, "_wr_n"},  a_wr_n, 1);
        chk({tag, "_ad_n"},  a_ad_n, 1);
        chk({tag, "_oe"},    a_oe, 0);
        chk({tag, "_busy"},  a_busy, 0);
        chk({tag, "_done"},  a_done, 0);
        chk({tag, "_bus"},   a_bus_out, 8'h00);
        chk({tag, "_rdata"}, a_rd_data, 8'h00);
        chk({tag, "_rv"},    a_rv, 0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; op = 1'b0; wr = 1'b0; ad = 1'b0;
        addr = '0; data_in = '0; bus_in = '0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        reset = 1'b0;
        repeat (2) @(negedge clk);

        //   t op wr ad addr   data   rb     exa exb lat cs wr rd oe ad rv bus
        xfer(2, 1, 1, 0, 4'h2, 8'h00, 8'h00, 0, 0, 9, 6, 2, 0, 6, 6, 0, 8'h02);
        xfer(2, 1, 1, 1, 4'h5, 8'hD2, 8'h00, 0, 0, 9, 6, 2, 0, 6, 0, 0, 8'hD2);
        xfer(2, 1, 0, 1, 4'h0, 8'h99, 8'h45, 0, 0, 9, 6, 0, 2, 0, 0, 1, 8'h00);
        xfer(2, 0, 1, 0, 4'h3, 8'h00, 8'h00, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8'h00);
        xfer(2, 1, 0, 0, 4'hB, 8'hFF, 8'h00, 0, 0, 9, 6, 2, 0, 6, 6, 0, 8'h0B);
        xfer(2, 1, 0, 1, 4'h0, 8'h00, 8'h3C, 0, 0, 9, 6, 0, 2, 0, 0, 1, 8'h00);

        // Read aborted by reset in its second strobe cycle; nothing queued, so any done is flagged.
        sel = 1'b0;
        @(negedge clk);
        start = 1'b1; op = 1'b1; wr = 1'b0; ad = 1'b1; addr = 4'h1; data_in = 8'h00;
        for (int n = 1; n <= 5; n++) begin
            @(negedge clk);
            start  = 1'b0;
            bus_in = 8'hEE;
            if (n == 4) reset = 1'b1;
        end
        chk_idle("abort");
        reset = 1'b0;
        repeat (12) @(negedge clk);

        xfer(2, 1, 1, 1, 4'h0, 8'h5A, 8'h00, 0, 0, 9, 6, 2, 0, 6, 0, 0, 8'h5A);
        xfer(1, 1, 1, 0, 4'h7, 8'h00, 8'h00, 3, 5, 5, 3, 1, 0, 3, 3, 0, 8'h07);
        xfer(1, 1, 0, 1, 4'h0, 8'h00, 8'hC3, 0, 0, 5, 3, 0, 1, 0, 0, 1, 8'h00);

        repeat (20) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
